mult_share_sched: RTL and testbench
===================================

# mult_share_sched

Round-robin scheduler and sequencer for one shared signed shift-add multiplier. Two requesters each present a pair of 8-bit two's-complement operands with a valid/ready handshake. The block grants one request at a time, runs the sign-magnitude shift-add sequence one multiplier bit per clock, applies the sign, and holds a full-width signed product until the consumer accepts it. It sits between the operand sources and the result consumer and owns the multiplier datapath outright.

## Interface
- `W`, default 8: operand width in bits, two's complement; product width is 2*W.
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-high; clears all state.
- `req0_valid` in 1: requester 0 has operands.
- `req0_a`, `req0_b` in W each: requester 0 multiplier (a) and multiplicand (b), signed.
- `req0_ready` out 1: requester 0 handshake accepted this cycle.
- `req1_valid`, `req1_a`, `req1_b`, `req1_ready`: same as requester 0, for requester 1.
- `res_valid` out 1: product available.
- `res_ready` in 1: consumer accepts the product.
- `res_product` out 2W: signed product a*b.
- `res_id` out 1: index of the requester that owns `res_product`.
- `busy` out 1: high whenever state is not IDLE.

## Operation
- States: IDLE, RUN, SIGN, DONE.
- **IDLE**
  - `reqN_ready` = IDLE && grant[N], decoded combinationally from the valids.
  - Sole valid requester wins.
  - Both valid: the requester not served last wins. The last-served pointer resets to 1, so requester 0 wins the first tie.
  - On the accept edge, capture |a| and |b| as W-bit unsigned values (|-2^(W-1)| = 2^(W-1) fits). Also capture sign = a[W-1]^b[W-1], the winner id, and clear the accumulator and iteration count. Update the pointer, then go to RUN.
- **RUN**, each edge:
  - If the exit condition holds, go to SIGN.
  - Otherwise, add the 2W-bit zero-extended multiplicand magnitude to the accumulator when the multiplier magnitude LSB is 1. Then shift the multiplier right by 1, shift the multiplicand left by 1, and increment the count.
  - Exit condition: count == W (see Configuration).
- **SIGN**: `res_product` = sign ? -acc : acc, computed mod 2^(2W). Go to DONE.
- **DONE**
  - `res_valid` = 1; `res_product` and `res_id` are held stable.
  - On `res_valid && res_ready`, go to IDLE. A new request can be accepted on the following cycle, never in the same cycle.
- Requesters must hold valid and operands until ready. Operands are sampled only on the accept edge, so later changes are ignored.
- Products to cover: -2^(W-1) * -2^(W-1) = 2^(2W-2) (W=8: 16384 = 0x4000); any zero operand gives 0 with no negative zero.
- Reset at any time: state IDLE, pointer = 1, all outputs 0 (`res_product` = 0, `res_id` = 0). An in-flight operation is discarded with no result.

## Timing
- The accept edge is E0. Without early termination:
  - RUN iterates on edges E1..EW.
  - E(W+1) moves to SIGN.
  - E(W+2) moves to DONE.
  - `res_valid` rises W+2 cycles after E0 (10 for W=8).
- Maximum throughput is one product per W+4 cycles (accept cycle, W+2 compute cycles, at least one DONE cycle).
- `busy` rises on E0 and falls on the result-handshake edge.
- Both ready outputs are 0 outside IDLE. At most one ready is high in any cycle.

## Configuration
- `MULT_EARLY_TERM_EN`
  - Defined: the RUN exit condition becomes (multiplier magnitude == 0) || count == W. Latency = 2 + bitlen(|a|), e.g. a=0 gives 2, a=1 gives 3, a=-128 gives 10. Results are identical to the fixed-latency build.
  - Undefined: exit only at count == W, giving a fixed latency of W+2.

## Test plan
- Reset: assert `reset` mid-RUN. All outputs go to 0 asynchronously. After release, req1 alone is accepted and completes normally with `res_id`=1.
- Single request: req0 a=7, b=-3. `res_product`=0xFFEB (-21), `res_id`=0, `res_valid` 10 cycles after accept (macro undefined).
- Tie and round-robin: both valid and held continuously. Grants go 0, 1, 0, 1. Each ready pulses for exactly one cycle, and never both in the same cycle.
- Extremes: a=-128, b=-128 gives 0x4000. a=-128, b=127 gives 0xC080 (-16256). a=0, b=-5 gives 0x0000.
- Backpressure: hold `res_ready`=0 for 5 cycles in DONE. Product, id and `res_valid` stay stable, and no ready is asserted. Raise `res_ready`; IDLE follows, and the next accept is no earlier than the cycle after.
- With `MULT_EARLY_TERM_EN`: a=0 gives latency 2; a=1, b=-1 gives 0xFFFF with latency 3; a=-128, b=1 gives 0xFF80 with latency 10.

Source files
------------

// File: rtl/mult_share_sched_if.sv
// mult_share_sched_if
// Handshake bundle between the two operand requesters, the shared multiplier
// scheduler and the result consumer.
//   req0_valid/req0_a/req0_b/req0_ready : requester 0 operands + handshake
//   req1_valid/req1_a/req1_b/req1_ready : requester 1 operands + handshake
//   res_valid/res_ready                 : product handshake toward consumer
//   res_product (2W)                    : signed product a*b
//   res_id                              : requester that owns res_product
//   busy                                : scheduler is not idle
// Modports: master = requesters/consumer side, slave = scheduler side.
interface mult_share_sched_if #(parameter int W = 8) ();
    logic             req0_valid;
    logic [W-1:0]     req0_a;
    logic [W-1:0]     req0_b;
    logic             req0_ready;
    logic             req1_valid;
    logic [W-1:0]     req1_a;
    logic [W-1:0]     req1_b;
    logic             req1_ready;
    logic             res_valid;
    logic             res_ready;
    logic [2*W-1:0]   res_product;
    logic             res_id;
    logic             busy;

    modport master (
        output req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b, res_ready,
        input  req0_ready, req1_ready, res_valid, res_product, res_id, busy
    );

    modport slave (
        input  req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b, res_ready,
        output req0_ready, req1_ready, res_valid, res_product, res_id, busy
    );
endinterface

// File: rtl/mult_share_sched.sv
// mult_share_sched
// Round-robin scheduler for one shared signed shift-add multiplier. Two
// requesters offer W-bit two's-complement operand pairs; one is granted at a
// time, the magnitudes are multiplied one multiplier bit per clock, the sign
// is applied and the 2W-bit product is held until the consumer takes it.
// Ports:
//   clk   : clock, rising edge
//   reset : asynchronous active-high reset
//   bus   : mult_share_sched_if.slave (requesters, result, busy)
// Optional build macro: MULT_EARLY_TERM_EN -- leave RUN as soon as the
// remaining multiplier magnitude is zero (data-dependent latency).
//
// state | meaning
// IDLE  | waiting for a request; readies decoded from the valids
// RUN   | one shift-add iteration per clock
// SIGN  | apply the product sign, register the result
// DONE  | result held with res_valid until res_ready
module mult_share_sched #(
    parameter int W = 8
) (
    input logic              clk,
    input logic              reset,
    mult_share_sched_if.slave bus
);
    localparam int CW = $clog2(W + 1);

    typedef enum logic [1:0] {IDLE, RUN, SIGN, DONE} state_t;

    state_t          state, state_nxt;
    logic            ptr;        // requester served last
    logic            grant0, grant1;
    logic [W-1:0]    sel_a, sel_b;
    logic [W-1:0]    mplier;
    logic [2*W-1:0]  mcand;
    logic [2*W-1:0]  acc;
    logic [2*W-1:0]  product;
    logic [CW-1:0]   cnt;
    logic            sgn;
    logic            id;
    logic            run_exit;

    // |x| as an unsigned W-bit value; the most negative input maps to 2^(W-1).
    function automatic logic [W-1:0] mag(input logic [W-1:0] x);
        return x[W-1] ? (~x + W'(1)) : x;
    endfunction

    // Readies are held low during reset so every output reads zero then.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (state == IDLE && !reset) begin
            if (bus.req0_valid && (!bus.req1_valid || ptr))
                grant0 = 1'b1;
            else if (bus.req1_valid)
                grant1 = 1'b1;
        end
    end

    assign sel_a = grant1 ? bus.req1_a : bus.req0_a;
    assign sel_b = grant1 ? bus.req1_b : bus.req0_b;

`ifdef MULT_EARLY_TERM_EN
    assign run_exit = (mplier == '0) || (cnt == CW'(W));
`else
    assign run_exit = (cnt == CW'(W));
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (grant0 || grant1) state_nxt = RUN;
            RUN:  if (run_exit)         state_nxt = SIGN;
            SIGN:                       state_nxt = DONE;
            DONE: if (bus.res_ready)    state_nxt = IDLE;
            default:                    state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr     <= 1'b1;
            mplier  <= '0;
            mcand   <= '0;
            acc     <= '0;
            product <= '0;
            cnt     <= '0;
            sgn     <= 1'b0;
            id      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant0 || grant1) begin
                        mplier <= mag(sel_a);
                        mcand  <= {{W{1'b0}}, mag(sel_b)};
                        sgn    <= sel_a[W-1] ^ sel_b[W-1];
                        id     <= grant1;
                        ptr    <= grant1;
                        acc    <= '0;
                        cnt    <= '0;
                    end
                end
                RUN: begin
                    if (!run_exit) begin
                        if (mplier[0])
                            acc <= acc + mcand;
                        mplier <= mplier >> 1;
                        mcand  <= mcand << 1;
                        cnt    <= cnt + CW'(1);
                    end
                end
                SIGN: begin
                    product <= sgn ? (~acc + (2*W)'(1)) : acc;
                end
                default: ;
            endcase
        end
    end

    assign bus.req0_ready  = grant0;
    assign bus.req1_ready  = grant1;
    assign bus.res_valid   = (state == DONE);
    assign bus.res_product = product;
    assign bus.res_id      = id;
    assign bus.busy        = (state != IDLE);
endmodule

// File: tb/tb_mult_share_sched.sv
module tb_mult_share_sched;
    localparam int W = 8;

`ifdef MULT_EARLY_TERM_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    typedef struct packed {
        logic        id;
        logic [15:0] prod;
    } exp_t;

    logic clk;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    mult_share_sched_if #(.W(W)) bus ();

    mult_share_sched #(.W(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] ref_prod(input logic signed [7:0] a, input logic signed [7:0] b);
        int p;
        p = int'(a) * int'(b);
        return p[15:0];
    endfunction

    function automatic int exp_lat(input logic signed [7:0] a);
        int m;
        int bl;
        m  = (a < 0) ? -int'(a) : int'(a);
        bl = 0;
        for (int i = 0; i < 8; i++)
            if (m[i]) bl = i + 1;
        return EARLY ? (2 + bl) : (W + 2);
    endfunction

    task automatic drive(input int r, input logic v, input logic [7:0] a, input logic [7:0] b);
        if (r == 0) begin
            bus.req0_valid = v; bus.req0_a = a; bus.req0_b = b;
        end else begin
            bus.req1_valid = v; bus.req1_a = a; bus.req1_b = b;
        end
    endtask

    task automatic push_exp(input int r, input logic signed [7:0] a, input logic signed [7:0] b);
        exp_t e;
        e.id   = (r == 1);
        e.prod = ref_prod(a, b);
        sb.push_back(e);
    endtask

    // Present a request, wait for its ready, and return just after the accept edge.
    task automatic start_op(input int r, input logic signed [7:0] a, input logic signed [7:0] b, output bit ok);
        int n = 0;
        drive(r, 1'b1, a, b);
        #1;
        while (!(r == 0 ? bus.req0_ready : bus.req1_ready) && n < 50) begin
            tick();
            n++;
        end
        ok = (n < 50);
        check("accept", {31'd0, ok}, 32'd1);
        if (ok) begin
            push_exp(r, a, b);
            tick();
        end
        // operands changed after the accept edge must be ignored
        drive(r, 1'b0, 8'($urandom), 8'($urandom));
    endtask

    task automatic finish_op(input int lat_exp);
        int   lat = 0;
        exp_t e;
        while (!bus.res_valid && lat < 60) begin
            tick();
            lat++;
        end
        check("latency", lat, lat_exp);
        bus.res_ready = 1'b1;
        e = sb.pop_front();
        check("product", {16'd0, bus.res_product}, {16'd0, e.prod});
        check("res_id", {31'd0, bus.res_id}, {31'd0, e.id});
        tick();
        bus.res_ready = 1'b0;
        check("idle_after_result", {30'd0, bus.busy, bus.res_valid}, 32'd0);
    endtask

    int tr[9] = '{0, 0, 1, 0, 1, 0, 1, 1, 0};
    int ta[9] = '{7, -128, -128, 0, 1, -128, 127, -1, 5};
    int tbv[9] = '{-3, -128, 127, -5, -1, 1, 127, -128, 0};

    initial begin
        bit   ok;
        int   lat;
        exp_t e;
        int   grants, results, both, longp;
        logic prev0, prev1;
        int   order[4];

        clk = 0;
        reset = 1;
        bus.res_ready = 0;
        drive(0, 1'b1, 8'd3, 8'd4);
        drive(1, 1'b1, 8'd5, 8'd6);
        #2;
        check("rst_req0_ready", {31'd0, bus.req0_ready}, 32'd0);
        check("rst_req1_ready", {31'd0, bus.req1_ready}, 32'd0);
        check("rst_res_valid", {31'd0, bus.res_valid}, 32'd0);
        check("rst_product", {16'd0, bus.res_product}, 32'd0);
        check("rst_id_busy", {30'd0, bus.res_id, bus.busy}, 32'd0);
        drive(0, 1'b0, 8'd0, 8'd0);
        drive(1, 1'b0, 8'd0, 8'd0);
        tick();
        tick();
        reset = 0;
        tick();

        // directed single requests including the extreme operand values
        for (int i = 0; i < 9; i++) begin
            start_op(tr[i], 8'(ta[i]), 8'(tbv[i]), ok);
            if (ok) finish_op(exp_lat(8'(ta[i])));
        end

        // result backpressure with a competing request pending
        start_op(1, -8'sd3, -8'sd7, ok);
        if (ok) begin
            lat = 0;
            while (!bus.res_valid && lat < 60) begin
                tick();
                lat++;
            end
            check("bp_latency", lat, exp_lat(-8'sd3));
            drive(0, 1'b1, 8'd9, 8'($signed(-11)));
            e = sb[0];
            repeat (5) begin
                check("bp_product", {16'd0, bus.res_product}, {16'd0, e.prod});
                check("bp_id", {31'd0, bus.res_id}, {31'd0, e.id});
                check("bp_valid", {31'd0, bus.res_valid}, 32'd1);
                check("bp_no_ready", {30'd0, bus.req0_ready, bus.req1_ready}, 32'd0);
                tick();
            end
            bus.res_ready = 1'b1;
            #1;
            check("bp_same_cycle_ready", {31'd0, bus.req0_ready}, 32'd0);
            e = sb.pop_front();
            check("bp_final_product", {16'd0, bus.res_product}, {16'd0, e.prod});
            tick();
            bus.res_ready = 1'b0;
            check("bp_busy_low", {31'd0, bus.busy}, 32'd0);
            check("bp_next_ready", {31'd0, bus.req0_ready}, 32'd1);
            push_exp(0, 8'sd9, -8'sd11);
            tick();
            drive(0, 1'b0, 8'($urandom), 8'($urandom));
            finish_op(exp_lat(8'sd9));
        end

        // leave a requester-1 result in the output register before the reset test
        start_op(1, 8'sd3, -8'sd4, ok);
        if (ok) finish_op(exp_lat(8'sd3));

        // reset in the middle of RUN discards the operation
        start_op(0, 8'sd100, -8'sd50, ok);
        repeat (4) tick();
        check("mid_busy_before_reset", {31'd0, bus.busy}, 32'd1);
        reset = 1;
        #1;
        check("mid_rst_valid", {31'd0, bus.res_valid}, 32'd0);
        check("mid_rst_product", {16'd0, bus.res_product}, 32'd0);
        check("mid_rst_id", {31'd0, bus.res_id}, 32'd0);
        check("mid_rst_busy", {31'd0, bus.busy}, 32'd0);
        sb.delete();
        tick();
        tick();
        reset = 0;
        tick();
        start_op(1, -8'sd6, 8'sd11, ok);
        if (ok) finish_op(exp_lat(-8'sd6));

        // tie: both requesters held valid, round-robin grants 0,1,0,1
        drive(0, 1'b1, 8'd5, 8'd6);
        drive(1, 1'b1, 8'($signed(-9)), 8'd4);
        bus.res_ready = 1'b1;
        grants = 0; results = 0; both = 0; longp = 0;
        prev0 = 0; prev1 = 0;
        for (int i = 0; i < 4; i++) order[i] = -1;
        #1;
        for (int cyc = 0; cyc < 400 && results < 4; cyc++) begin
            if (bus.req0_ready && bus.req1_ready) both++;
            if ((bus.req0_ready && prev0) || (bus.req1_ready && prev1)) longp++;
            prev0 = bus.req0_ready;
            prev1 = bus.req1_ready;
            if (bus.req0_ready || bus.req1_ready) begin
                if (grants < 4) order[grants] = bus.req1_ready ? 1 : 0;
                if (bus.req1_ready) push_exp(1, -8'sd9, 8'sd4);
                else                push_exp(0, 8'sd5, 8'sd6);
                grants++;
            end else if (grants >= 4) begin
                drive(0, 1'b0, 8'd0, 8'd0);
                drive(1, 1'b0, 8'd0, 8'd0);
            end
            if (bus.res_valid && sb.size() > 0) begin
                e = sb.pop_front();
                check("tie_product", {16'd0, bus.res_product}, {16'd0, e.prod});
                check("tie_id", {31'd0, bus.res_id}, {31'd0, e.id});
                results++;
            end
            tick();
        end
        bus.res_ready = 1'b0;
        drive(0, 1'b0, 8'd0, 8'd0);
        drive(1, 1'b0, 8'd0, 8'd0);
        check("tie_results", results, 32'd4);
        check("tie_grants", grants, 32'd4);
        check("tie_both_ready", both, 32'd0);
        check("tie_ready_pulse", longp, 32'd0);
        for (int i = 0; i < 4; i++)
            check("tie_order", order[i], i % 2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
